// File: rtl/mem_port_arbiter_if.sv
// Groups the fetch, load/store and memory-port signals of the memory port arbiter.
// Latency: none (signal bundle only).
// Backpressure: carried by stall (to the pipeline) and bus_ack (from the memory port).
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // IF stage requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;

    // MEM stage requester
    logic              m_MemRead;
    logic              m_MemWrite;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_be;
    logic [DATA_W-1:0] m_rdata;

    // Shared memory port
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_be;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    // Pipeline control and status
    logic              stall;
    logic              bus_err;

    // Arbiter side
    modport master (
        input  if_req, if_addr,
        input  m_MemRead, m_MemWrite, m_addr, m_wdata, m_be,
        input  bus_ack, bus_rdata,
        output if_rdata, m_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output stall, bus_err
    );

    // Pipeline / memory side
    modport slave (
        output if_req, if_addr,
        output m_MemRead, m_MemWrite, m_addr, m_wdata, m_be,
        output bus_ack, bus_rdata,
        input  if_rdata, m_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  stall, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data access wins (older instr).
// Latency: request seen in IDLE at N -> bus_req N+1 -> earliest ack N+1 -> rdata and stall release N+2.
// Backpressure: stall freezes the whole pipeline until every access requested this step is served.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.master port
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              d_req;
    logic              d_pend;
    logic              i_pend;
    logic              d_done;
    logic              i_done;
    logic              ack_hit;
    logic              timeout_hit;
    logic              xfer_end;
    logic [CNT_W-1:0]  wait_cnt;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [3:0]        cap_be;
    logic [DATA_W-1:0] xfer_rdata;

    // An access is still owed to the pipeline until its done flag is set.
    assign d_req   = port.m_MemRead | port.m_MemWrite;
    assign d_pend  = d_req & ~d_done;
    assign i_pend  = port.if_req & ~i_done;

    // Gated by rst_n so the pipeline is released the moment reset asserts.
    assign port.stall   = rst_n & (d_pend | i_pend);
    assign port.bus_req = (state != IDLE);

    // Ack arriving on the timeout cycle counts as a normal completion.
    assign ack_hit     = port.bus_req & port.bus_ack;
    assign timeout_hit = port.bus_req & ~port.bus_ack & (wait_cnt == CNT_W'(TIMEOUT));
    assign xfer_end    = ack_hit | timeout_hit;
    assign xfer_rdata  = ack_hit ? port.bus_rdata : '0;

    // Payload to launch from IDLE: the data access takes precedence over the fetch.
    always_comb begin
        cap_we   = 1'b0;
        cap_addr = port.if_addr;
        cap_be   = 4'hF;
        if (d_pend) begin
            cap_we   = port.m_MemWrite;
            cap_addr = port.m_addr;
            if (port.m_MemWrite) begin
                cap_be = port.m_be;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: launch data before fetch, return to IDLE on ack or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_pend) begin
                    state_nxt = DATA;
                end else if (i_pend) begin
                    state_nxt = FETCH;
                end
            end
            DATA, FETCH: begin
                if (xfer_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the payload on launch and hold it while bus_req is high; count wait cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port.bus_we    <= 1'b0;
            port.bus_addr  <= '0;
            port.bus_wdata <= '0;
            port.bus_be    <= 4'h0;
            wait_cnt       <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
            if (d_pend | i_pend) begin
                port.bus_we   <= cap_we;
                port.bus_addr <= cap_addr;
                port.bus_be   <= cap_be;
            end
            if (d_pend) begin
                port.bus_wdata <= port.m_wdata;
            end
        end else if (!port.bus_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Return read data to the requester; an aborted read returns zero. Stores leave m_rdata alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port.m_rdata  <= '0;
            port.if_rdata <= '0;
        end else if (xfer_end) begin
            if ((state == DATA) && !port.bus_we) begin
                port.m_rdata <= xfer_rdata;
            end
            if (state == FETCH) begin
                port.if_rdata <= xfer_rdata;
            end
        end
    end

    // Done flags live for one stall episode; they clear as soon as the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else if (!port.stall) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else if (xfer_end) begin
            if (state == DATA) begin
                d_done <= 1'b1;
            end
            if (state == FETCH) begin
                i_done <= 1'b1;
            end
        end
    end

    // Sticky error on any aborted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port.bus_err <= 1'b0;
        end else if (timeout_hit) begin
            port.bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases followed by randomized steps.
// Each step's expected bus transactions, read data, error and stall length come from a reference model.
// The bench acts as the memory, acknowledging each transfer after a chosen delay.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) port ();

    mem_port_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .port (port)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        int            k;      // bus_req cycle index on which the memory acks; > TO means never
        logic [DW-1:0] rd;
    } txn_t;

    txn_t          exp_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] mdl_m_rdata;
    logic [DW-1:0] mdl_if_rdata;
    logic          mdl_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_wait(input int k);
        return (k > TO) ? TO : k;
    endfunction

    function automatic int pick_k();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return r % 4;
        if (r == 7) return TO;
        return TO + 1 + $urandom_range(0, 2);
    endfunction

    // One pipeline step: present the requests, serve the port until stall drops, check results.
    // dkind: 0 none, 1 load, 2 store. Entered and left just after a falling edge.
    task automatic run_step(input string tag, input int dkind,
                            input logic [AW-1:0] daddr, input logic [DW-1:0] wd,
                            input logic [3:0] be, input int kd, input logic [DW-1:0] rdd,
                            input bit iv, input logic [AW-1:0] iaddr,
                            input int ki, input logic [DW-1:0] rdi);
        txn_t t;
        txn_t cur;
        int   exp_stall = 0;
        int   stall_cyc = 0;
        int   cyc = 0;
        bit   in_txn = 0;
        bit   done = 0;

        exp_q.delete();
        cur = '{we: 1'b0, addr: '0, wdata: '0, be: 4'h0, k: 0, rd: '0};
        if (dkind != 0) begin
            t.we    = (dkind == 2);
            t.addr  = daddr;
            t.wdata = wd;
            t.be    = t.we ? be : 4'hF;
            t.k     = kd;
            t.rd    = rdd;
            exp_q.push_back(t);
            exp_stall += 2 + eff_wait(kd);
            if (dkind == 1) mdl_m_rdata = (kd <= TO) ? rdd : '0;
            if (kd > TO) mdl_err = 1'b1;
        end
        if (iv) begin
            t.we    = 1'b0;
            t.addr  = iaddr;
            t.wdata = '0;
            t.be    = 4'hF;
            t.k     = ki;
            t.rd    = rdi;
            exp_q.push_back(t);
            exp_stall += 2 + eff_wait(ki);
            mdl_if_rdata = (ki <= TO) ? rdi : '0;
            if (ki > TO) mdl_err = 1'b1;
        end

        port.m_MemRead  = (dkind == 1);
        port.m_MemWrite = (dkind == 2);
        port.m_addr     = daddr;
        port.m_wdata    = wd;
        port.m_be       = be;
        port.if_req     = iv;
        port.if_addr    = iaddr;

        for (int g = 0; g < 200 && !done; g++) begin
            #1;
            if (!port.stall) begin
                done = 1;
            end else begin
                stall_cyc++;
                port.bus_ack   = 1'b0;
                port.bus_rdata = $urandom;
                if (port.bus_req) begin
                    if (!in_txn) begin
                        check({tag, " txn_expected"}, 64'(exp_q.size() > 0), 64'd1);
                        if (exp_q.size() > 0) cur = exp_q.pop_front();
                        else cur.k = 0;
                        in_txn = 1;
                        cyc    = 0;
                    end
                    check({tag, " bus_addr"}, port.bus_addr, cur.addr);
                    check({tag, " bus_we"}, port.bus_we, cur.we);
                    check({tag, " bus_be"}, port.bus_be, cur.be);
                    if (cur.we) check({tag, " bus_wdata"}, port.bus_wdata, cur.wdata);
                    if (cyc == cur.k && cur.k <= TO) begin
                        port.bus_ack   = 1'b1;
                        port.bus_rdata = cur.rd;
                        in_txn         = 0;
                    end else if (cyc == TO) begin
                        in_txn = 0;
                    end
                    cyc++;
                end else begin
                    if (in_txn) check({tag, " bus_req_held"}, port.bus_req, 1'b1);
                    in_txn       = 0;
                    port.bus_ack = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
        end

        port.bus_ack = 1'b0;
        check({tag, " stall_released"}, done, 1'b1);
        check({tag, " stall_cycles"}, stall_cyc, exp_stall);
        check({tag, " txns_left"}, exp_q.size(), 0);
        check({tag, " bus_req_idle"}, port.bus_req, 1'b0);
        check({tag, " m_rdata"}, port.m_rdata, mdl_m_rdata);
        check({tag, " if_rdata"}, port.if_rdata, mdl_if_rdata);
        check({tag, " bus_err"}, port.bus_err, mdl_err);

        port.m_MemRead  = 1'b0;
        port.m_MemWrite = 1'b0;
        port.if_req     = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            dk;
        bit            iv;
        logic [DW-1:0] m_before;

        port.if_req     = 1'b0;
        port.if_addr    = '0;
        port.m_MemRead  = 1'b0;
        port.m_MemWrite = 1'b0;
        port.m_addr     = '0;
        port.m_wdata    = '0;
        port.m_be       = 4'h0;
        port.bus_ack    = 1'b0;
        port.bus_rdata  = '0;
        mdl_m_rdata     = '0;
        mdl_if_rdata    = '0;
        mdl_err         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst bus_req", port.bus_req, 1'b0);
        check("rst bus_we", port.bus_we, 1'b0);
        check("rst bus_addr", port.bus_addr, 0);
        check("rst bus_wdata", port.bus_wdata, 0);
        check("rst bus_be", port.bus_be, 4'h0);
        check("rst m_rdata", port.m_rdata, 0);
        check("rst if_rdata", port.if_rdata, 0);
        check("rst stall", port.stall, 1'b0);
        check("rst bus_err", port.bus_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single load, acked on first bus cycle
        run_step("t1_load", 1, 32'h100, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0, 32'h0, 0, 32'h0);

        // Store and fetch together: store first, m_rdata untouched
        m_before = mdl_m_rdata;
        run_step("t2_store_fetch", 2, 32'h200, 32'h12345678, 4'b0011, 0, 32'hDEAD0001,
                 1, 32'h40, 0, 32'h00000013);
        check("t2 m_rdata_unchanged", port.m_rdata, m_before);

        // Fetch with ack held off three cycles
        run_step("t3_fetch_slow", 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1, 32'h44, 3, 32'hA5A5A5A5);

        // Ack lands on the timeout cycle: normal completion
        run_step("t5_ack_at_timeout", 1, 32'h300, 32'h0, 4'h0, TO, 32'h55, 0, 32'h0, 0, 32'h0);

        // No ack at all: abort, zero data, sticky error
        run_step("t4_timeout", 1, 32'h304, 32'h0, 4'h0, TO + 1, 32'hFFFF, 0, 32'h0, 0, 32'h0);
        run_step("t4_err_sticky", 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1, 32'h48, 1, 32'h11112222);

        // Reset in the middle of a load
        port.m_MemRead = 1'b1;
        port.m_addr    = 32'h400;
        port.bus_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t6 bus_req_before_rst", port.bus_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6 bus_req_in_rst", port.bus_req, 1'b0);
        check("t6 stall_in_rst", port.stall, 1'b0);
        check("t6 bus_err_in_rst", port.bus_err, 1'b0);
        check("t6 m_rdata_in_rst", port.m_rdata, 0);
        port.m_MemRead = 1'b0;
        mdl_m_rdata    = '0;
        mdl_if_rdata   = '0;
        mdl_err        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_step("t6_fresh_load", 1, 32'h404, 32'h0, 4'h0, 1, 32'h600DF00D, 0, 32'h0, 0, 32'h0);

        // Randomized steps
        for (int s = 0; s < 60; s++) begin
            dk = $urandom_range(0, 2);
            iv = 1'($urandom_range(0, 1));
            if (dk == 0 && !iv) iv = 1'b1;
            run_step("rand", dk, $urandom, $urandom, 4'($urandom_range(0, 15)), pick_k(), $urandom,
                     iv, $urandom, pick_k(), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
